mem_bus_arbiter: RTL

- Shares the core's single AXI4-Lite master bus between two requesters: instruction fetch (read-only) and the MEM-stage data port (read/write).
- Converts each requester's simple req/done handshake into one complete AXI transaction (AR/R, or AW+W/B).
- Issues one transaction at a time and returns read data and a response-error flag to the granted requester.
- Sits between the fetch/memory-control logic of the multicycle core and the MMU bus.

---
 rtl/mem_arb_pkg.sv | 32 +++
 rtl/mem_arb_pick.sv | 42 ++++
 rtl/mem_bus_arbiter.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pkg
// Purpose  : Shared types and constants for the memory bus arbiter: FSM state
//            encoding, grant encoding and AXI response codes.
// Revision : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

  // Arbiter FSM states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_ADDR = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_WR_RESP = 3'd4
  } arb_state_e;

  // Which requester owns the bus
  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_D  = 1'b1
  } gnt_e;

  // AXI response code for a successful access
  localparam logic [1:0] RESP_OKAY = 2'b00;

  // Data bits covered by one write strobe; strobe width = DATA_W / BITS_PER_STRB
  localparam int BITS_PER_STRB = 8;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/mem_arb_pick.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pick
// Purpose  : Combinational grant selection between fetch and data requesters.
//            Build option MEM_ARB_RR_EN: round-robin on simultaneous requests
//            (the port not granted last wins); otherwise data has fixed
//            priority over fetch.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic if_req,
  input  logic d_req,
  input  gnt_e last_gnt,
  output logic gnt_valid,
  output gnt_e gnt
);

  // Select the winner; with no request the previous grant is simply echoed
  always_comb begin
    gnt_valid = if_req | d_req;
    gnt       = last_gnt;
`ifdef MEM_ARB_RR_EN
    if (if_req && d_req) begin
      gnt = (last_gnt == GNT_D) ? GNT_IF : GNT_D;
    end else if (d_req) begin
      gnt = GNT_D;
    end else if (if_req) begin
      gnt = GNT_IF;
    end
`else
    if (d_req) begin
      gnt = GNT_D;
    end else if (if_req) begin
      gnt = GNT_IF;
    end
`endif
  end

endmodule : mem_arb_pick
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_arbiter
// Purpose  : Shares one AXI4-Lite master between instruction fetch (read
//            only) and the data port (read/write). Each req/done handshake is
//            turned into a single complete AXI transaction, one at a time.
//            Build option MEM_ARB_RR_EN: round-robin arbitration with a 1-bit
//            last-grant pointer; default is fixed data-over-fetch priority.
// Revision : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  // fetch port
  input  logic                              if_req,
  input  logic [ADDR_W-1:0]                 if_addr,
  output logic [DATA_W-1:0]                 if_rdata,
  output logic                              if_done,
  output logic                              if_err,
  // data port
  input  logic                              d_req,
  input  logic                              d_we,
  input  logic [ADDR_W-1:0]                 d_addr,
  input  logic [DATA_W-1:0]                 d_wdata,
  input  logic [DATA_W/BITS_PER_STRB-1:0]   d_wstrb,
  output logic [DATA_W-1:0]                 d_rdata,
  output logic                              d_done,
  output logic                              d_err,
  output logic                              busy,
  // AXI4-Lite master
  output logic [ADDR_W-1:0]                 axi_araddr,
  output logic                              axi_arvalid,
  input  logic                              axi_arready,
  input  logic [DATA_W-1:0]                 axi_rdata,
  input  logic [1:0]                        axi_rresp,
  input  logic                              axi_rvalid,
  output logic                              axi_rready,
  output logic [ADDR_W-1:0]                 axi_awaddr,
  output logic                              axi_awvalid,
  input  logic                              axi_awready,
  output logic [DATA_W-1:0]                 axi_wdata,
  output logic [DATA_W/BITS_PER_STRB-1:0]   axi_wstrb,
  output logic                              axi_wvalid,
  input  logic                              axi_wready,
  input  logic [1:0]                        axi_bresp,
  input  logic                              axi_bvalid,
  output logic                              axi_bready
);

  localparam int STRB_W = DATA_W / BITS_PER_STRB;

  arb_state_e           state_q,   state_d;
  gnt_e                 gnt_q,     gnt_d;
  logic [ADDR_W-1:0]    araddr_q,  araddr_d;
  logic [ADDR_W-1:0]    awaddr_q,  awaddr_d;
  logic [DATA_W-1:0]    wdata_q,   wdata_d;
  logic [STRB_W-1:0]    wstrb_q,   wstrb_d;
  logic                 arvalid_q, arvalid_d;
  logic                 rready_q,  rready_d;
  logic                 awvalid_q, awvalid_d;
  logic                 wvalid_q,  wvalid_d;
  logic                 bready_q,  bready_d;
  logic                 aw_ok_q,   aw_ok_d;
  logic                 w_ok_q,    w_ok_d;
  logic [DATA_W-1:0]    if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]    d_rdata_q,  d_rdata_d;
  logic                 if_done_q, if_done_d;
  logic                 if_err_q,  if_err_d;
  logic                 d_done_q,  d_done_d;
  logic                 d_err_q,   d_err_d;

  gnt_e                 last_gnt;
  gnt_e                 pick_gnt;
  logic                 pick_valid;
  logic                 grant_fire;
  logic                 aw_hs, w_hs, aw_all, w_all;

  mem_arb_pick u_pick (
    .if_req    (if_req),
    .d_req     (d_req),
    .last_gnt  (last_gnt),
    .gnt_valid (pick_valid),
    .gnt       (pick_gnt)
  );

  // A requester drops req on the edge after its done pulse, so IDLE ignores
  // requests while a done pulse is out; otherwise the stale req level would
  // launch a duplicate transaction.
  assign grant_fire = (state_q == ST_IDLE) && pick_valid && !(if_done_q || d_done_q);

`ifdef MEM_ARB_RR_EN
  gnt_e rr_ptr_q, rr_ptr_d;

  // Round-robin pointer remembers the most recent grant
  always_comb begin
    rr_ptr_d = grant_fire ? pick_gnt : rr_ptr_q;
  end

  // Pointer register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_ptr_q <= GNT_IF;
    else     rr_ptr_q <= rr_ptr_d;
  end

  assign last_gnt = rr_ptr_q;
`else
  assign last_gnt = gnt_q;
`endif

  assign aw_hs  = awvalid_q & axi_awready;
  assign w_hs   = wvalid_q & axi_wready;
  assign aw_all = aw_ok_q | aw_hs;
  assign w_all  = w_ok_q | w_hs;

  // Next-state and registered-output logic of the transaction FSM
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    araddr_d   = araddr_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    arvalid_d  = arvalid_q;
    rready_d   = rready_q;
    awvalid_d  = awvalid_q;
    wvalid_d   = wvalid_q;
    bready_d   = bready_q;
    aw_ok_d    = aw_ok_q;
    w_ok_d     = w_ok_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    if_done_d  = 1'b0;
    if_err_d   = 1'b0;
    d_done_d   = 1'b0;
    d_err_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (grant_fire) begin
          gnt_d = pick_gnt;
          if (pick_gnt == GNT_D && d_we) begin
            awaddr_d  = d_addr;
            wdata_d   = d_wdata;
            wstrb_d   = d_wstrb;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_ok_d   = 1'b0;
            w_ok_d    = 1'b0;
            state_d   = ST_WR_REQ;
          end else begin
            araddr_d  = (pick_gnt == GNT_D) ? d_addr : if_addr;
            arvalid_d = 1'b1;
            state_d   = ST_RD_ADDR;
          end
        end
      end
      ST_RD_ADDR: begin
        if (arvalid_q && axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_RD_DATA;
        end
      end
      ST_RD_DATA: begin
        if (axi_rvalid && rready_q) begin
          rready_d = 1'b0;
          if (gnt_q == GNT_D) begin
            d_rdata_d = axi_rdata;
            d_done_d  = 1'b1;
            d_err_d   = (axi_rresp != RESP_OKAY);
          end else begin
            if_rdata_d = axi_rdata;
            if_done_d  = 1'b1;
            if_err_d   = (axi_rresp != RESP_OKAY);
          end
          state_d = ST_IDLE;
        end
      end
      ST_WR_REQ: begin
        // Address and data channels complete independently
        if (aw_hs) awvalid_d = 1'b0;
        if (w_hs)  wvalid_d  = 1'b0;
        aw_ok_d = aw_all;
        w_ok_d  = w_all;
        if (aw_all && w_all) begin
          bready_d = 1'b1;
          state_d  = ST_WR_RESP;
        end
      end
      ST_WR_RESP: begin
        if (axi_bvalid && bready_q) begin
          bready_d = 1'b0;
          d_done_d = 1'b1;
          d_err_d  = (axi_bresp != RESP_OKAY);
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset abandons any transaction in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      gnt_q      <= GNT_IF;
      araddr_q   <= '0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      bready_q   <= 1'b0;
      aw_ok_q    <= 1'b0;
      w_ok_q     <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      if_done_q  <= 1'b0;
      if_err_q   <= 1'b0;
      d_done_q   <= 1'b0;
      d_err_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      araddr_q   <= araddr_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      arvalid_q  <= arvalid_d;
      rready_q   <= rready_d;
      awvalid_q  <= awvalid_d;
      wvalid_q   <= wvalid_d;
      bready_q   <= bready_d;
      aw_ok_q    <= aw_ok_d;
      w_ok_q     <= w_ok_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      if_done_q  <= if_done_d;
      if_err_q   <= if_err_d;
      d_done_q   <= d_done_d;
      d_err_q    <= d_err_d;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign if_rdata    = if_rdata_q;
  assign if_done     = if_done_q;
  assign if_err      = if_err_q;
  assign d_rdata     = d_rdata_q;
  assign d_done      = d_done_q;
  assign d_err       = d_err_q;
  assign axi_araddr  = araddr_q;
  assign axi_arvalid = arvalid_q;
  assign axi_rready  = rready_q;
  assign axi_awaddr  = awaddr_q;
  assign axi_awvalid = awvalid_q;
  assign axi_wdata   = wdata_q;
  assign axi_wstrb   = wstrb_q;
  assign axi_wvalid  = wvalid_q;
  assign axi_bready  = bready_q;

endmodule : mem_bus_arbiter
`default_nettype wire
